// File: rtl/armored_enc_ilv.sv
// rtl/armored_enc_ilv.sv - scrambler, 40/33 ECC and D-deep diagonal bit interleaver; ARMORED_ILV_FLUSH_EN adds a flush port
// Output word k of a block carries bit b of codeword (b+k) mod D.

module ecc_enc_40_33 #(
  parameter int TARGET_CHIP = 2
) (
  input  logic        clk,
  input  logic        sclr_n,
  input  logic [32:0] data_i,
  output logic [39:0] code_o
);

  logic [5:0]  syn;
  logic [5:0]  idx;
  logic [39:0] code_d;
  logic [39:0] code_q;

  // Data bits sit on the non-power-of-two Hamming positions 3..39; bit 39 is overall parity.
  always_comb begin
    syn = '0;
    idx = '0;
    for (int p = 1; p < 40; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (data_i[idx]) syn = syn ^ 6'(p);
        idx = idx + 6'd1;
      end
    end
    code_d = {^{syn, data_i}, syn, data_i};
  end

  if (TARGET_CHIP == 0) begin : g_noreset
    always_ff @(posedge clk) code_q <= code_d;
  end else begin : g_reset
    always_ff @(posedge clk) begin
      if (!sclr_n) code_q <= '0;
      else         code_q <= code_d;
    end
  end

  assign code_o = code_q;

endmodule

module armored_enc_ilv #(
  parameter int          TARGET_CHIP = 2,
  parameter logic [57:0] SCRAM_INIT  = 58'h12345678,
  parameter int          ILV_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        sclr_n,
  input  logic [32:0] din,
  input  logic        din_valid,
`ifdef ARMORED_ILV_FLUSH_EN
  input  logic        flush,
`endif
  output logic [39:0] dout,
  output logic        dout_valid,
  output logic        dout_sop
);

  localparam int            CW        = $clog2(ILV_DEPTH);
  localparam logic [CW-1:0] LAST_SLOT = CW'(ILV_DEPTH - 1);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  logic [57:0]   scr_state_q, scr_state_d;
  logic [32:0]   scr_data_q, scr_data_d;
  logic          scr_valid_q;
  logic          scr_bit;

  logic [39:0]   enc_code;
  logic          enc_valid_q;

  logic [39:0]   bank_q [2][ILV_DEPTH];
  logic [CW-1:0] fill_cnt_q, fill_cnt_d;
  logic          fill_bank_q, fill_bank_d;
  logic [1:0]    full_q, full_d;
  logic          wr_en, wr_last;
  logic [39:0]   wr_data;

  state_t        state_q, state_d;
  logic          drain_bank_q, drain_bank_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d;
  logic          drain_done, out_load;
  logic [39:0]   ilv_word;
  logic [CW-1:0] ilv_slot;

  logic [39:0]   dout_q;
  logic          dout_valid_q, dout_sop_q;

  // Multiplicative scrambler 1+x^39+x^58, bit 0 first; scr_state_d[0] is the newest output bit.
  always_comb begin
    scr_state_d = scr_state_q;
    scr_data_d  = '0;
    scr_bit     = 1'b0;
    for (int i = 0; i < 33; i++) begin
      scr_bit       = din[i] ^ scr_state_d[38] ^ scr_state_d[57];
      scr_data_d[i] = scr_bit;
      scr_state_d   = {scr_state_d[56:0], scr_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      scr_state_q <= SCRAM_INIT;
      scr_data_q  <= '0;
      scr_valid_q <= 1'b0;
    end else begin
      scr_valid_q <= din_valid;
      if (din_valid) begin
        scr_state_q <= scr_state_d;
        scr_data_q  <= scr_data_d;
      end
    end
  end

  ecc_enc_40_33 #(
    .TARGET_CHIP(TARGET_CHIP)
  ) u_ecc (
    .clk    (clk),
    .sclr_n (sclr_n),
    .data_i (scr_data_q),
    .code_o (enc_code)
  );

`ifdef ARMORED_ILV_FLUSH_EN
  logic [1:0] flush_dly_q;
  logic       flush_pend_q, flush_pend_d;

  // A flush only arms when there is a partial bank or a word arriving alongside it.
  always_comb begin
    flush_pend_d = flush_pend_q;
    if (wr_last)
      flush_pend_d = 1'b0;
    else if (flush_dly_q[1] && (enc_valid_q || (fill_cnt_q != '0)))
      flush_pend_d = 1'b1;
    else if (!enc_valid_q && (fill_cnt_q == '0))
      flush_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      flush_dly_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      flush_dly_q  <= {flush_dly_q[0], flush};
      flush_pend_q <= flush_pend_d;
    end
  end
`endif

  always_comb begin
    wr_en   = enc_valid_q;
    wr_data = enc_code;
`ifdef ARMORED_ILV_FLUSH_EN
    if (!enc_valid_q && flush_pend_q && (fill_cnt_q != '0)) begin
      wr_en   = 1'b1;
      wr_data = '0;
    end
`endif
  end

  assign wr_last = wr_en && (fill_cnt_q == LAST_SLOT);

  always_comb begin
    fill_cnt_d  = fill_cnt_q;
    fill_bank_d = fill_bank_q;
    full_d      = full_q;
    if (wr_en) begin
      if (wr_last) begin
        fill_cnt_d          = '0;
        fill_bank_d         = ~fill_bank_q;
        full_d[fill_bank_q] = 1'b1;
      end else begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end
    if (drain_done) full_d[drain_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) bank_q[fill_bank_q][fill_cnt_q] <= wr_data;
  end

  // Banks drain in the order they fill; chaining into the other bank avoids an idle cycle.
  always_comb begin
    state_d      = state_q;
    drain_bank_d = drain_bank_q;
    drain_cnt_d  = drain_cnt_q;
    drain_done   = 1'b0;
    out_load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full_q[drain_bank_q]) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        out_load = 1'b1;
        if (drain_cnt_q == LAST_SLOT) begin
          drain_done   = 1'b1;
          drain_bank_d = ~drain_bank_q;
          drain_cnt_d  = '0;
          state_d      = full_q[~drain_bank_q] ? S_DRAIN : S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ilv_word = '0;
    ilv_slot = '0;
    for (int b = 0; b < 40; b++) begin
      ilv_slot    = CW'(b) + drain_cnt_q;
      ilv_word[b] = bank_q[drain_bank_q][ilv_slot][b];
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      enc_valid_q  <= 1'b0;
      fill_cnt_q   <= '0;
      fill_bank_q  <= 1'b0;
      full_q       <= '0;
      state_q      <= S_IDLE;
      drain_bank_q <= 1'b0;
      drain_cnt_q  <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sop_q   <= 1'b0;
    end else begin
      enc_valid_q  <= scr_valid_q;
      fill_cnt_q   <= fill_cnt_d;
      fill_bank_q  <= fill_bank_d;
      full_q       <= full_d;
      state_q      <= state_d;
      drain_bank_q <= drain_bank_d;
      drain_cnt_q  <= drain_cnt_d;
      dout_valid_q <= out_load;
      dout_sop_q   <= out_load && (drain_cnt_q == '0);
      if (out_load) dout_q <= ilv_word;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_sop   = dout_sop_q;

endmodule

// File: tb/tb_armored_enc_ilv.sv
// tb/tb_armored_enc_ilv.sv - directed self-checking bench for armored_enc_ilv (D=4 and D=2 instances)
module tb_armored_enc_ilv;

  localparam logic [57:0] SINIT = 58'h12345678;
  localparam logic [32:0] VEC [8] = '{33'h0_0000_0001, 33'h1_FFFF_FFFF, 33'h0_A5A5_A5A5, 33'h1_5A5A_5A5A,
                                      33'h0_1234_5678, 33'h1_8765_4321, 33'h0_0000_0000, 33'h1_0F0F_F0F0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sclr4_n, vld4, dv4, sop4;
  logic [32:0] din4;
  logic [39:0] dout4;
  logic        sclr2_n, vld2, dv2, sop2;
  logic [32:0] din2;
  logic [39:0] dout2;
`ifdef ARMORED_ILV_FLUSH_EN
  logic        flush4;
`endif

  armored_enc_ilv #(.TARGET_CHIP(2), .SCRAM_INIT(SINIT), .ILV_DEPTH(4)) u_d4 (
    .clk(clk), .sclr_n(sclr4_n), .din(din4), .din_valid(vld4),
`ifdef ARMORED_ILV_FLUSH_EN
    .flush(flush4),
`endif
    .dout(dout4), .dout_valid(dv4), .dout_sop(sop4));

  armored_enc_ilv #(.TARGET_CHIP(2), .SCRAM_INIT(SINIT), .ILV_DEPTH(2)) u_d2 (
    .clk(clk), .sclr_n(sclr2_n), .din(din2), .din_valid(vld2),
`ifdef ARMORED_ILV_FLUSH_EN
    .flush(1'b0),
`endif
    .dout(dout2), .dout_valid(dv2), .dout_sop(sop2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  int pos_tab [33];

  function automatic logic [39:0] m_ecc(input logic [32:0] d);
    logic [6:0] c = '0;
    for (int j = 0; j < 6; j++)
      for (int i = 0; i < 33; i++)
        if (((pos_tab[i] >> j) & 1) == 1) c[j] = c[j] ^ d[i];
    c[6] = ^{c[5:0], d};
    return {c, d};
  endfunction

  function automatic logic [90:0] m_scr(input logic [57:0] st, input logic [32:0] d);
    logic [32:0] o;
    for (int i = 0; i < 33; i++) begin
      o[i] = d[i] ^ st[38] ^ st[57];
      st   = {st[56:0], o[i]};
    end
    return {st, o};
  endfunction

  function automatic logic [39:0] m_ilv(input logic [39:0] blk [4], input int k);
    logic [39:0] w;
    for (int b = 0; b < 40; b++) w[b] = blk[(b + k) % 4][b];
    return w;
  endfunction

  logic [57:0] m_st4;
  logic [39:0] blk4 [$];
  logic [40:0] exp4 [$];
  logic [39:0] rx4 [$];
  time         sop_t4 [$];
  time         last_t4, first_t4, lastv_t4, t_w3;
  bit          got4;
  int          n_out4 = 0;

  logic [32:0] sent2 [$];
  logic [39:0] rx2 [$];
  logic        sopq2 [$];
  time         first_t2, last_t2;
  int          n_out2 = 0;

  task automatic model_code4(input logic [39:0] c);
    logic [39:0] a [4];
    blk4.push_back(c);
    if (blk4.size() == 4) begin
      for (int i = 0; i < 4; i++) a[i] = blk4[i];
      for (int k = 0; k < 4; k++) exp4.push_back({(k == 0), m_ilv(a, k)});
      blk4.delete();
    end
  endtask

  task automatic drv4(input logic v, input logic [32:0] d);
    logic [90:0] r;
    @(negedge clk);
    din4 = d;
    vld4 = v;
    @(posedge clk);
    if (v) begin
      r = m_scr(m_st4, d);
      m_st4 = r[90:33];
      model_code4(m_ecc(r[32:0]));
      last_t4 = $time;
    end
  endtask

  task automatic drv2(input logic v, input logic [32:0] d);
    @(negedge clk);
    din2 = d;
    vld2 = v;
    @(posedge clk);
    if (v) sent2.push_back(d);
  endtask

  task automatic wait_drain4(input string tag, input int budget);
    int n = 0;
    while (exp4.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, 64'(exp4.size()), 64'd0);
  endtask

  task automatic clear4();
    sop_t4.delete();
    rx4.delete();
    n_out4 = 0;
    got4 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (dv4 === 1'b1) begin
      logic [40:0] e;
      n_out4++;
      rx4.push_back(dout4);
      if (!got4) begin
        first_t4 = $time;
        got4 = 1'b1;
      end
      lastv_t4 = $time;
      if (sop4) sop_t4.push_back($time - 5);
      if (exp4.size() == 0) begin
        check("d4_spurious_valid", 64'(dv4), 64'd0);
      end else begin
        e = exp4.pop_front();
        check("d4_dout", 64'(dout4), 64'(e[39:0]));
        check("d4_sop", 64'(sop4), 64'(e[40]));
      end
    end
  end

  always @(negedge clk) begin
    if (dv2 === 1'b1) begin
      if (n_out2 == 0) first_t2 = $time;
      last_t2 = $time;
      n_out2++;
      rx2.push_back(dout2);
      sopq2.push_back(sop2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int          pi;
    int          n;
    logic [39:0] c;
    logic [32:0] d;
    logic [57:0] h;
    logic [5:0]  syn;
    logic [39:0] mask;

    pi = 0;
    for (int q = 1; q < 40; q++)
      if ((q & (q - 1)) != 0) begin
        pos_tab[pi] = q;
        pi++;
      end

    sclr4_n = 1'b0; sclr2_n = 1'b0;
    din4 = '0; vld4 = 1'b0; din2 = '0; vld2 = 1'b0;
`ifdef ARMORED_ILV_FLUSH_EN
    flush4 = 1'b0;
`endif
    m_st4 = SINIT;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_d4_dout", 64'(dout4), 64'd0);
    check("rst_d4_valid", 64'(dv4), 64'd0);
    check("rst_d4_sop", 64'(sop4), 64'd0);
    check("rst_d2_dout", 64'(dout2), 64'd0);
    check("rst_d2_valid", 64'(dv2), 64'd0);
    check("rst_d4_scram", 64'(u_d4.scr_state_q), 64'(SINIT));
    sclr4_n = 1'b1; sclr2_n = 1'b1;

    // 8 back-to-back words on D=4
    clear4();
    for (int i = 0; i < 8; i++) begin
      drv4(1'b1, VEC[i]);
      if (i == 3) t_w3 = last_t4;
    end
    drv4(1'b0, '0);
    wait_drain4("t1_drain", 30);
    check("t1_nwords", 64'(n_out4), 64'd8);
    check("t1_nsop", 64'(sop_t4.size()), 64'd2);
    if (sop_t4.size() >= 2) begin
      check("t1_sop_latency", 64'(sop_t4[0] - t_w3), 64'd40);
      check("t1_sop_spacing", 64'(sop_t4[1] - sop_t4[0]), 64'd40);
    end
    check("t1_contiguous", 64'(lastv_t4 - first_t4), 64'd70);

    // gapped input 1,0,0,1,0,1,1
    clear4();
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if ((7'b1101001 >> i) & 7'd1) begin
        drv4(1'b1, VEC[7 - n]);
        n++;
      end else begin
        drv4(1'b0, 33'h1_DEAD_BEEF);
      end
    end
    drv4(1'b0, '0);
    wait_drain4("t2_drain", 30);
    check("t2_nwords", 64'(n_out4), 64'd4);
    check("t2_nsop", 64'(sop_t4.size()), 64'd1);
    if (sop_t4.size() >= 1) check("t2_sop_latency", 64'(sop_t4[0] - last_t4), 64'd40);
    check("t2_contiguous", 64'(lastv_t4 - first_t4), 64'd30);
    check("t2_scram_steps", 64'(u_d4.scr_state_q), 64'(m_st4));

    // reset during word 2 of a drain
    clear4();
    for (int i = 0; i < 4; i++) drv4(1'b1, VEC[i]);
    drv4(1'b0, '0);
    n = 0;
    while (sop4 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3_sop_seen", 64'(sop4), 64'd1);
    @(negedge clk);
    @(negedge clk);
    sclr4_n = 1'b0;
    @(posedge clk);
    #1;
    exp4.delete();
    blk4.delete();
    m_st4 = SINIT;
    @(negedge clk);
    check("t3_valid_in_reset", 64'(dv4), 64'd0);
    check("t3_dout_in_reset", 64'(dout4), 64'd0);
    sclr4_n = 1'b1;
    @(negedge clk);
    check("t3_valid_after_reset", 64'(dv4), 64'd0);
    for (int i = 4; i < 8; i++) drv4(1'b1, VEC[i]);
    drv4(1'b0, '0);
    wait_drain4("t3_drain", 30);
    check("t3_nwords", 64'(n_out4), 64'd7);

    // D=2 continuous stream of 100 words
    for (int i = 0; i < 100; i++) drv2(1'b1, {i[0], 32'(i) * 32'h9E37_79B9});
    drv2(1'b0, '0);
    n = 0;
    while (n_out2 < 100 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("t4_nwords", 64'(n_out2), 64'd100);
    check("t4_contiguous", 64'(last_t2 - first_t2), 64'd990);
    if (rx2.size() >= 100 && sent2.size() >= 100) begin
      h = SINIT;
      for (int j = 0; j < 50; j++) begin
        check("t4_sop", 64'(sopq2[2*j]), 64'd1);
        for (int s = 0; s < 2; s++) begin
          for (int b = 0; b < 40; b++) c[b] = rx2[2*j + (((s - b) % 2 + 2) % 2)][b];
          syn = c[38:33];
          for (int i = 0; i < 33; i++) if (c[i]) syn = syn ^ 6'(pos_tab[i]);
          check("t4_syndrome", 64'({syn, ^c}), 64'd0);
          for (int i = 0; i < 33; i++) begin
            d[i] = c[i] ^ h[38] ^ h[57];
            h = {h[56:0], c[i]};
          end
          check("t4_roundtrip", 64'(d), 64'(sent2[2*j + s]));
        end
      end
    end

`ifdef ARMORED_ILV_FLUSH_EN
    // 2 words then flush: zero padding completes the block
    clear4();
    drv4(1'b1, VEC[1]);
    drv4(1'b1, VEC[2]);
    @(negedge clk);
    flush4 = 1'b1;
    vld4 = 1'b0;
    @(posedge clk);
    model_code4(40'h0);
    model_code4(40'h0);
    @(negedge clk);
    flush4 = 1'b0;
    wait_drain4("t5_drain", 30);
    check("t5_nwords", 64'(n_out4), 64'd4);
    if (rx4.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        mask = '0;
        for (int b = 0; b < 40; b++) if (((b + k) % 4) >= 2) mask[b] = 1'b1;
        check("t5_pad_bits", 64'(rx4[rx4.size() - 4 + k] & mask), 64'd0);
      end
    end
    check("t5_pend_clear", 64'(u_d4.flush_pend_q), 64'd0);

    // flush with nothing buffered or in flight
    clear4();
    repeat (3) @(negedge clk);
    flush4 = 1'b1;
    @(negedge clk);
    flush4 = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_no_output", 64'(n_out4), 64'd0);
    check("t6_pend_clear", 64'(u_d4.flush_pend_q), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
